// File: rtl/gate_preact_mac_if.sv
// Handshake/bus bundle between a pre-activation MAC and its producer/consumer.
// W is the full signed fixed-point word width (QN+QM+1).
interface gate_preact_mac_if #(
  parameter int W = 18
);
  logic                start;
  logic signed [W-1:0] bias;
  logic                in_valid;
  logic signed [W-1:0] weight;
  logic signed [W-1:0] data;
  logic                in_ready;
  logic signed [W-1:0] result;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output start, bias, in_valid, weight, data, out_ready,
    input  in_ready, result, out_valid, busy
  );

  modport slave (
    input  start, bias, in_valid, weight, data, out_ready,
    output in_ready, result, out_valid, busy
  );
endinterface

// File: rtl/gate_preact_mac.sv
// Gate pre-activation multiply-accumulate: bias + sum of NTERMS weight*data products,
// rescaled to the Q(QN).(QM) word and saturated before handoff to the activation stage.
module gate_preact_mac #(
  parameter int QN     = 6,
  parameter int QM     = 11,
  parameter int NTERMS = 8
) (
  input  logic clk,
  input  logic reset,
  gate_preact_mac_if.slave bus
);
  localparam int W    = QN + QM + 1;
  localparam int PW   = 2 * W;
  localparam int ACCW = PW + $clog2(NTERMS) + 1;
  localparam int CW   = $clog2(NTERMS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [W-1:0]    result_q, result_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic signed [PW-1:0]   w_ext_s, d_ext_s, prod_s;
  logic signed [ACCW-1:0] prod_ext_s, bias_ext_s, shifted_s;
  logic signed [W-1:0]    sat_s;

  // Full-precision product, bias alignment and floor-rescale with clamp.
  always_comb begin
    w_ext_s    = {{(PW-W){bus.weight[W-1]}}, bus.weight};
    d_ext_s    = {{(PW-W){bus.data[W-1]}}, bus.data};
    prod_s     = w_ext_s * d_ext_s;
    prod_ext_s = {{(ACCW-PW){prod_s[PW-1]}}, prod_s};
    bias_ext_s = {{(ACCW-W-QM){bus.bias[W-1]}}, bus.bias, {QM{1'b0}}};
    shifted_s  = acc_q >>> QM;
    // In range only when every bit above the result sign bit matches it.
    if (shifted_s[ACCW-1:W-1] == {(ACCW-W+1){shifted_s[ACCW-1]}}) begin
      sat_s = shifted_s[W-1:0];
    end else begin
      sat_s = {shifted_s[ACCW-1], {(W-1){~shifted_s[ACCW-1]}}};
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACC;
          acc_d   = bias_ext_s;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = acc_q + prod_ext_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NTERMS - 1)) begin
            state_d = SAT;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      SAT: begin
        result_d = sat_s;
        state_d  = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= {ACCW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      result_q    <= {W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_gate_preact_mac.sv
// Directed table-driven bench for gate_preact_mac (QN=6, QM=11, NTERMS=4; 1.0 = 2048).
module tb_gate_preact_mac;
  localparam int W = 18;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  gate_preact_mac_if #(.W(W)) bus ();

  gate_preact_mac #(.QN(6), .QM(11), .NTERMS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] b;
    logic signed [W-1:0] w;
    logic signed [W-1:0] d;
    logic signed [W-1:0] exp;
    int                  gap;
    int                  stall;
    bit                  poke;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One full operation: start, NTERMS pairs (optionally gapped), SAT, OUT with stall, handoff.
  task automatic run_op(input vec_t v, input string nm);
    int accepted;
    int gapcnt;
    int cyc;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bias  = v.b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    accepted = 0;
    gapcnt   = 0;
    cyc      = 0;
    while (accepted < 4 && cyc < 100) begin
      bus.in_valid = (gapcnt == 0);
      bus.weight   = v.w;
      bus.data     = v.d;
      if (v.poke && cyc == 1) begin
        bus.start = 1'b1;
        bus.bias  = 18'sd50000;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        accepted++;
        gapcnt = v.gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk({nm, "_accepted"}, accepted, 4);
    @(negedge clk);
    chk({nm, "_sat_no_valid"}, bus.out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_latency_valid"}, bus.out_valid, 1);
    chk({nm, "_result"}, bus.result, v.exp);
    for (int i = 0; i < v.stall; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "_stall_valid"}, bus.out_valid, 1);
      chk({nm, "_stall_result"}, bus.result, v.exp);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    if (v.poke) begin
      bus.start = 1'b1;
      bus.bias  = 18'sd777;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_busy"}, bus.busy, 0);
    chk({nm, "_idle_valid"}, bus.out_valid, 0);
    chk({nm, "_idle_hold"}, bus.result, v.exp);
  endtask

  initial begin
    bit seen_valid;
    n_cmp = 0;
    n_bad = 0;
    //            bias        weight       data        expected     gap stall poke
    tbl[0] = '{18'sd0,      18'sd2048,   18'sd1024,  18'sd4096,    0, 0, 1'b0};
    tbl[1] = '{-18'sd2048,  -18'sd2048,  18'sd2048,  -18'sd10240,  0, 0, 1'b0};
    tbl[2] = '{18'sd0,      18'sd131071, 18'sd131071, 18'sd131071, 0, 0, 1'b0};
    tbl[3] = '{18'sd0,      -18'sd131072, 18'sd131071, -18'sd131072, 0, 0, 1'b0};
    tbl[4] = '{18'sd0,      18'sd1,      18'sd1,     18'sd0,       0, 0, 1'b0};
    tbl[5] = '{18'sd0,      -18'sd1,     18'sd1,     -18'sd1,      0, 0, 1'b0};
    tbl[6] = '{18'sd0,      18'sd2048,   18'sd1024,  18'sd4096,    2, 5, 1'b0};
    tbl[7] = '{18'sd100,    18'sd3,      18'sd5,     18'sd100,     0, 1, 1'b0};
    tbl[8] = '{-18'sd131072, 18'sd0,     18'sd9,     -18'sd131072, 0, 0, 1'b0};
    tbl[9] = '{-18'sd2048,  -18'sd2048,  18'sd2048,  -18'sd10240,  1, 2, 1'b1};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.weight    = '0;
    bus.data      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
    end

    // Abort after two accepted pairs, then a clean bias-only run.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bias  = 18'sd5000;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.weight   = 18'sd1000;
    bus.data     = 18'sd1000;
    @(negedge clk);
    chk("abort_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready_low", bus.in_ready, 0);
    chk("abort_result_cleared", bus.result, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen_valid = 1'b1;
    end
    chk("abort_no_out_valid", seen_valid, 0);
    run_op('{18'sd2048, 18'sd0, 18'sd0, 18'sd2048, 0, 0, 1'b0}, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
